// File: rtl/neural_unit_param_if.sv
// Layer-side bus of one neuron: input vector, weight write port, start/mode control and result.
interface neural_unit_param_if #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 8,
  parameter int ADDR_W   = 2
);
  logic [N_INPUTS*DATA_W-1:0] in_vec;
  logic [WEIGHT_W-1:0]        weight;
  logic [ADDR_W-1:0]          address;
  logic                       write;
  logic                       start;
  logic [1:0]                 mode;
  logic signed [DATA_W-1:0]   layer_out;
  logic                       busy;
  logic                       layer_done;

  modport master (
    output in_vec, weight, address, write, start, mode,
    input  layer_out, busy, layer_done
  );

  modport slave (
    input  in_vec, weight, address, write, start, mode,
    output layer_out, busy, layer_done
  );
endinterface

// File: rtl/neural_unit_param.sv
// Sequential neuron: shift/negate-weighted saturating accumulation of N_INPUTS values,
// followed by a linear, ReLU or Elliot (x/(1+|x|), restoring divider) activation.
module neural_unit_param #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int WEIGHT_W = 8,
  parameter int ADDR_W   = 2
) (
  input logic                clk,
  input logic                reset,
  neural_unit_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, ACT, DIV} state_e;

  localparam int SW    = WEIGHT_W - 1;
  localparam int WW    = 2 * DATA_W;
  localparam int DW    = DATA_W + FRAC_W + 1;
  localparam int CNT_W = (FRAC_W > 1) ? $clog2(FRAC_W) : 1;

  localparam logic signed [DATA_W-1:0] MAXV   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0]     WMAX   = {{DATA_W{1'b0}}, MAXV};
  localparam logic signed [WW-1:0]     WMIN   = -WMAX;
  localparam logic [DW-1:0]            ONE_DW = DW'(1) << FRAC_W;

  // Symmetric clamp: the most negative code is never produced.
  function automatic logic signed [DATA_W-1:0] clampWide(input logic signed [WW-1:0] v);
    if (v > WMAX) return MAXV;
    else if (v < WMIN) return -MAXV;
    else return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] termOf(input logic signed [DATA_W-1:0] x,
                                                     input logic [WEIGHT_W-1:0] w);
    logic signed [SW-1:0]     s;
    logic signed [WW-1:0]     ext;
    logic signed [WW-1:0]     wide;
    logic signed [DATA_W-1:0] t;
    int                       sh;
    s    = w[SW-1:0];
    sh   = int'(s);
    ext  = {{DATA_W{x[DATA_W-1]}}, x};
    if (sh >= DATA_W)
      wide = (x == 0) ? '0 : ((x < 0) ? WMIN : WMAX);
    else if (sh >= 0)
      wide = ext <<< sh;
    else if (-sh >= DATA_W)
      wide = (x < 0) ? '1 : '0;
    else
      wide = ext >>> (-sh);
    t = clampWide(wide);
    if (w[WEIGHT_W-1]) t = -t;
    return t;
  endfunction

  state_e                   state_q, state_d;
  logic [WEIGHT_W-1:0]      weights_q [N_INPUTS];
  logic [WEIGHT_W-1:0]      weights_d [N_INPUTS];
  logic signed [DATA_W-1:0] inputs_q  [N_INPUTS];
  logic signed [DATA_W-1:0] inputs_d  [N_INPUTS];
  logic [1:0]               mode_q, mode_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic [DW-1:0]            rem_q, rem_d;
  logic [DW-1:0]            divisor_q, divisor_d;
  logic [FRAC_W-1:0]        quot_q, quot_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     done_q, done_d;

  logic signed [DATA_W-1:0] curTerm;
  logic signed [WW-1:0]     sumWide;
  logic [DATA_W-1:0]        absAcc;
  logic [DW-1:0]            remShift;
  logic                     qBit;
  logic [FRAC_W-1:0]        quotNext;
  logic signed [DATA_W-1:0] qExt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < N_INPUTS; i++) begin
        weights_q[i] <= '0;
        inputs_q[i]  <= '0;
      end
      mode_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      weights_q <= weights_d;
      inputs_q  <= inputs_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    weights_d = weights_q;
    inputs_d  = inputs_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    done_d    = 1'b0;

    curTerm  = termOf(inputs_q[idx_q], weights_q[idx_q]);
    sumWide  = {{DATA_W{acc_q[DATA_W-1]}}, acc_q} + {{DATA_W{curTerm[DATA_W-1]}}, curTerm};
    absAcc   = acc_q[DATA_W-1] ? -acc_q : acc_q;
    remShift = rem_q << 1;
    qBit     = (remShift >= divisor_q);
    quotNext = (quot_q << 1) | FRAC_W'(qBit);
    qExt     = DATA_W'(quotNext);

    // Weights are frozen for the whole evaluation so every term sees one weight set.
    if (state_q == IDLE && bus.write && (32'(bus.address) < N_INPUTS))
      weights_d[bus.address] = bus.weight;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < N_INPUTS; i++)
            inputs_d[i] = bus.in_vec[i*DATA_W +: DATA_W];
          mode_d  = bus.mode;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = clampWide(sumWide);
        if (idx_q == ADDR_W'(N_INPUTS - 1)) state_d = ACT;
        else idx_d = idx_q + ADDR_W'(1);
      end
      ACT: begin
        case (mode_q)
          2'd1: begin
            out_d   = (acc_q < 0) ? '0 : acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end
          2'd2: begin
            rem_d     = DW'(absAcc);
            divisor_d = ONE_DW + DW'(absAcc);
            quot_d    = '0;
            cnt_d     = '0;
            state_d   = DIV;
          end
          default: begin
            out_d   = acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      DIV: begin
        rem_d  = qBit ? (remShift - divisor_q) : remShift;
        quot_d = quotNext;
        if (cnt_q == CNT_W'(FRAC_W - 1)) begin
          out_d   = acc_q[DATA_W-1] ? -qExt : qExt;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.layer_out  = out_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.layer_done = done_q;

endmodule

// File: tb/tb_neural_unit_param.sv
// Bench for neural_unit_param: directed literal cases plus random traffic, all checked
// every cycle against an arithmetic model of the neuron.
module tb_neural_unit_param;
  localparam int     N    = 4;
  localparam int     DW   = 32;
  localparam int     FW   = 16;
  localparam int     WW   = 8;
  localparam int     AW   = 2;
  localparam longint MAXV = 64'sd2147483647;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  neural_unit_param_if #(.N_INPUTS(N), .DATA_W(DW), .WEIGHT_W(WW), .ADDR_W(AW)) bus ();
  neural_unit_param #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(FW), .WEIGHT_W(WW), .ADDR_W(AW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  neural_unit_param_if #(.N_INPUTS(3), .DATA_W(DW), .WEIGHT_W(WW), .ADDR_W(AW)) bus3 ();
  neural_unit_param #(.N_INPUTS(3), .DATA_W(DW), .FRAC_W(FW), .WEIGHT_W(WW), .ADDR_W(AW))
    dut3 (.clk(clk), .reset(reset), .bus(bus3));

  function automatic longint clampL(input longint v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  function automatic longint termL(input longint x, input logic [7:0] w);
    int     s;
    longint t;
    longint p;
    s = int'($signed(w[6:0]));
    if (s >= 32) t = (x == 0) ? 0 : ((x > 0) ? MAXV : -MAXV);
    else if (s >= 0) t = clampL(x * (longint'(1) << s));
    else if (-s >= 32) t = (x < 0) ? -1 : 0;
    else begin
      p = longint'(1) << (-s);
      t = (x >= 0) ? x / p : -((-x + p - 1) / p);
    end
    if (w[7]) t = -t;
    return t;
  endfunction

  function automatic longint evalL(input longint xs[N], input logic [7:0] ws[N],
                                   input logic [1:0] m);
    longint acc;
    longint a;
    longint q;
    acc = 0;
    for (int i = 0; i < N; i++) acc = clampL(acc + termL(xs[i], ws[i]));
    case (m)
      2'd1: return (acc < 0) ? 0 : acc;
      2'd2: begin
        a = (acc < 0) ? -acc : acc;
        q = (a * 65536) / (65536 + a);
        return (acc < 0) ? -q : q;
      end
      default: return acc;
    endcase
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: advances on each clock edge from the same pins the DUT sees.
  logic [7:0]         mW [N] = '{default: 8'h00};
  logic               mBusy   = 1'b0;
  int                 mLeft   = 0;
  longint             mResult = 0;
  logic signed [31:0] expOut  = '0;
  logic               expDone = 1'b0;

  initial forever begin
    longint xs [N];
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < N; i++) mW[i] = 8'h00;
      mBusy = 1'b0; mLeft = 0; expOut = '0; expDone = 1'b0;
    end else begin
      expDone = 1'b0;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          expOut = 32'(mResult); expDone = 1'b1; mBusy = 1'b0;
        end
      end else begin
        if (bus.write && int'(bus.address) < N) mW[bus.address] = bus.weight;
        if (bus.start) begin
          for (int i = 0; i < N; i++) xs[i] = longint'($signed(bus.in_vec[i*32 +: 32]));
          mResult = evalL(xs, mW, bus.mode);
          mLeft   = N + 1 + ((bus.mode == 2'd2) ? FW : 0);
          mBusy   = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    checkOutput("layer_out", longint'(bus.layer_out), longint'(expOut));
    checkOutput("busy", longint'(bus.busy), longint'(mBusy));
    checkOutput("layer_done", longint'(bus.layer_done), longint'(expDone));
    checkOutput("done_and_busy", longint'(bus.layer_done & bus.busy), 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic writeWeight(input int addr, input logic [7:0] w);
    bus.address = AW'(addr);
    bus.weight  = w;
    bus.write   = 1'b1;
    tick();
    bus.write   = 1'b0;
  endtask

  task automatic setWeights(input logic [7:0] w0, w1, w2, w3);
    writeWeight(0, w0); writeWeight(1, w1); writeWeight(2, w2); writeWeight(3, w3);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!bus.layer_done && n < 200) begin tick(); n++; end
    checkOutput(name, longint'(bus.layer_done), 1);
  endtask

  task automatic applyStimulus(input int a0, a1, a2, a3, input logic [1:0] m,
                               output longint res, output int lat);
    bus.in_vec = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    bus.mode   = m;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    lat = 0;
    while (!bus.layer_done && lat < 200) begin tick(); lat++; end
    checkOutput("done_seen", longint'(bus.layer_done), 1);
    res = longint'(bus.layer_out);
  endtask

  task automatic checkRun(input string name, input int a0, a1, a2, a3, input logic [1:0] m,
                          input longint expected, input int expLat);
    longint res;
    int     lat;
    applyStimulus(a0, a1, a2, a3, m, res, lat);
    checkOutput(name, res, expected);
    checkOutput({name, "_latency"}, lat, expLat);
  endtask

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'(int'($urandom_range(0, 524288)) - 262144);
      2:       return 32'h0;
      default: return ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h80000001;
    endcase
  endfunction

  function automatic logic [7:0] randWeight();
    int s;
    if ($urandom_range(0, 1) == 1) return 8'($urandom);
    s = int'($urandom_range(0, 8)) - 4;
    return {1'($urandom_range(0, 1)), 7'(s)};
  endfunction

  initial begin
    int doneCount;
    int n;
    bus.in_vec = '0; bus.weight = '0; bus.address = '0;
    bus.write = 1'b0; bus.start = 1'b0; bus.mode = '0;
    bus3.in_vec = '0; bus3.weight = '0; bus3.address = '0;
    bus3.write = 1'b0; bus3.start = 1'b0; bus3.mode = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_layer_out", longint'(bus.layer_out), 0);
    checkOutput("reset_busy", longint'(bus.busy), 0);

    checkRun("sum_linear", 65536, 131072, 196608, 262144, 2'd0, 655360, 5);
    setWeights(8'h01, 8'h7F, 8'h80, 8'h02);
    checkRun("mixed_weights", 262144, 262144, 262144, 262144, 2'd0, 1441792, 5);
    setWeights(8'h80, 8'h80, 8'h80, 8'h80);
    checkRun("negated_linear", 65536, 65536, 65536, 65536, 2'd0, -262144, 5);
    checkRun("negated_relu", 65536, 65536, 65536, 65536, 2'd1, 0, 5);
    checkRun("negated_mode3", 65536, 65536, 65536, 65536, 2'd3, -262144, 5);
    setWeights(8'h00, 8'h00, 8'h00, 8'h00);
    checkRun("elliot_pos", 65536, 0, 0, 0, 2'd2, 32768, 21);
    checkRun("elliot_neg", -196608, 0, 0, 0, 2'd2, -49152, 21);
    checkRun("elliot_zero", 0, 0, 0, 0, 2'd2, 0, 21);

    setWeights(8'h01, 8'h01, 8'h01, 8'h01);
    checkRun("sat_pos", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'd0, MAXV, 5);
    setWeights(8'h00, 8'h00, 8'h00, 8'h00);
    checkRun("sat_neg", -2147483647, -2147483647, -2147483647, -2147483647, 2'd0, -MAXV, 5);
    writeWeight(0, 8'h20);
    checkRun("shift_32", 1, 0, 0, 0, 2'd0, MAXV, 5);
    writeWeight(0, 8'h60);
    checkRun("shift_m32", -1, 0, 0, 0, 2'd0, -1, 5);

    // A second start mid-run must neither restart nor produce a second done pulse.
    writeWeight(0, 8'h00);
    bus.in_vec = {4{32'd65536}}; bus.mode = 2'd0; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    doneCount = 0;
    repeat (15) begin tick(); if (bus.layer_done) doneCount++; end
    checkOutput("start_while_busy_dones", doneCount, 1);
    checkOutput("start_while_busy_out", longint'(bus.layer_out), 262144);

    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    writeWeight(0, 8'h01);
    waitDone("write_busy_done");
    checkRun("write_while_busy", 65536, 65536, 65536, 65536, 2'd0, 262144, 5);

    bus3.address = 2'd3; bus3.weight = 8'h01; bus3.write = 1'b1;
    tick();
    bus3.address = 2'd0;
    tick();
    bus3.write = 1'b0;
    bus3.in_vec = {3{32'd65536}}; bus3.mode = 2'd0; bus3.start = 1'b1;
    tick(); bus3.start = 1'b0;
    n = 0;
    while (!bus3.layer_done && n < 50) begin tick(); n++; end
    checkOutput("n3_done_seen", longint'(bus3.layer_done), 1);
    checkOutput("n3_latency", n, 4);
    checkOutput("n3_out", longint'(bus3.layer_out), 262144);

    setWeights(8'h01, 8'h01, 8'h01, 8'h01);
    bus.in_vec = {32'd0, 32'd0, 32'd0, 32'd65536}; bus.mode = 2'd2; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    repeat (10) tick();
    checkOutput("pre_reset_busy", longint'(bus.busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_div_reset_busy", longint'(bus.busy), 0);
    checkOutput("mid_div_reset_out", longint'(bus.layer_out), 0);
    tick();
    reset = 1'b0;
    tick();
    checkRun("after_reset", 65536, 65536, 65536, 65536, 2'd0, 262144, 5);

    // Random traffic: starts and writes at any time, including while busy.
    for (int c = 0; c < 600; c++) begin
      bus.write   = ($urandom_range(0, 3) == 0);
      bus.address = AW'($urandom);
      bus.weight  = randWeight();
      bus.start   = ($urandom_range(0, 2) == 0);
      bus.mode    = 2'($urandom);
      for (int i = 0; i < N; i++) bus.in_vec[i*32 +: 32] = randVal();
      tick();
    end
    bus.write = 1'b0;
    bus.start = 1'b0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neural_unit_param.md
Name: neural_unit_param

Overview:
- Parametrised, sequential successor of the 4-input neuron.
- N_INPUTS signed fixed-point inputs are scaled by per-input power-of-two weights (signed shift plus negate) and accumulated serially with saturation.
- The sum then passes through a selectable activation: linear, ReLU, or an Elliot function x/(1+|x|) using an iterative divider.
- Sits between the layer input bus and the next layer; one instance per neuron.

Parameters:
- N_INPUTS, 4, number of inputs (>=1).
- DATA_W, 32, signed fixed-point data width.
- FRAC_W, 16, fractional bits (ONE = 1<<FRAC_W); FRAC_W < DATA_W-1.
- WEIGHT_W, 8, weight word width (>=3).
- ADDR_W, 2, weight address width; 2**ADDR_W >= N_INPUTS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_vec  in  N_INPUTS*DATA_W  inputs; input i = in_vec[i*DATA_W +: DATA_W], signed.
- weight  in  WEIGHT_W  weight write data.
- address  in  ADDR_W  weight write index.
- write  in  1  weight write strobe.
- start  in  1  begin evaluation (single-cycle pulse or level).
- mode  in  2  activation: 0 linear, 1 ReLU, 2 Elliot, 3 treated as linear.
- layer_out  out  DATA_W  result, signed, held until next completion.
- busy  out  1  evaluation in progress.
- layer_done  out  1  one-cycle pulse when layer_out updates.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset clears all weights to 0 and returns state to IDLE. Outputs: layer_out=0, busy=0, layer_done=0.
- Reset mid-operation aborts immediately with the same values.
- Weight encoding: bit WEIGHT_W-1 = negate flag; bits [WEIGHT_W-2:0] = two's-complement shift s.
  - s>0: term = in<<s, saturated to signed DATA_W. Saturates if |s|>=DATA_W and in!=0.
  - s<0: term = in>>>(-s), arithmetic. -s>=DATA_W gives 0 or -1.
  - Negate flag then negates the term.
- Weight write: on clk edge with write=1, busy=0 and address<N_INPUTS, weight[address] <= weight.
  - Writes while busy, or to address>=N_INPUTS, are dropped.
- Value range: accumulator and terms use the symmetric range [-(2^(DATA_W-1)-1), +(2^(DATA_W-1)-1)].
  - Every result clamps to this range, so -2^(DATA_W-1) is never produced.
- FSM:
  - IDLE: start=1 at edge k latches in_vec and mode, clears acc, busy<=1, idx<=0, goes to ACCUM.
  - ACCUM: edges k+1..k+N_INPUTS, one term per edge; acc <= sat(acc + term(idx)). After idx=N_INPUTS-1, goes to ACT.
  - ACT, edge k+N_INPUTS+1:
    - Linear: layer_out<=acc.
    - ReLU: layer_out<=max(acc,0).
    - For linear/ReLU: layer_done<=1, busy<=0, go to IDLE.
    - Elliot: load dividend |acc|<<FRAC_W and divisor ONE+|acc| (DATA_W+FRAC_W+1-bit internal, no overflow), go to DIV.
  - DIV: restoring divide, one quotient bit per edge, FRAC_W edges (quotient < ONE). Final edge: layer_out <= sign(acc) ? -q : q, layer_done<=1, busy<=0, go to IDLE.
- Latency, start edge to layer_done high: N_INPUTS+1 cycles (linear/ReLU), N_INPUTS+1+FRAC_W cycles (Elliot). Elliot result truncates toward zero.
- start while busy is ignored. start in the same cycle as the done-producing edge is ignored. start in the cycle after done is accepted (back-to-back).
- layer_done is never high with busy=1. layer_out changes only on layer_done edges.

Test Plan:
1. Defaults (N=4, DATA_W=32, FRAC_W=16, WEIGHT_W=8).
   - Reset weights; inputs 65536,131072,196608,262144; mode 0 → layer_out=655360 (10.0).
   - layer_done exactly 5 cycles after start; busy high for those 5 cycles.
2. Weights w0=0x01, w1=0x7F, w2=0x80, w3=0x02; inputs all 262144 (4.0) → 8+2-4+16=22.0 → layer_out=1441792.
3. Weights all 0x80; inputs all 65536.
   - mode 0 → layer_out=-262144.
   - mode 1 → layer_out=0.
   - mode 3 → -262144.
4. Elliot (mode 2), default weights:
   - inputs {65536,0,0,0} → 32768 (0.5), layer_done 21 cycles after start.
   - inputs {-196608,0,0,0} → -49152.
   - all-zero → 0.
5. Saturation:
   - Inputs all 0x7FFFFFFF, weights 0x01 → 0x7FFFFFFF.
   - Inputs all 0x80000001, linear → 0x80000001.
   - Weight 0x20 (shift 32) on input 1 → 0x7FFFFFFF.
   - Weight 0x60 (shift -32) on input -1 → -1.
6. Control corners:
   - start during busy → no restart, single layer_done.
   - write during busy → weight unchanged on next run.
   - write to address 3 with N_INPUTS=3 → ignored.
   - reset asserted mid-DIV → busy=0, layer_out=0, weights 0 asynchronously; next start works.
